aes128_inv_core: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) and the decrypt counterpart of `AES128_core`. It uses the same word-serial interface: 4 × 32-bit ciphertext and key words in, 4 × 32-bit plaintext words out, most-significant word first. It sits beside the encrypt core behind the same message-processing front end. It expands the key forward, then runs ten inverse rounds at one round per clock, regenerating round keys backwards on the fly.

---
 rtl/aes_pkg.sv | 134 +++++++++++++
 rtl/aes128_key_sched_rev.sv | 66 ++++++
 rtl/aes128_inv_core.sv | 164 ++++++++++++++++
 tb/tb_aes128_inv_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 definitions for the encrypt and decrypt
//                cores: forward/inverse S-boxes, Rcon table, the 4x4 state
//                type, the core FSM state encoding and the byte/word
//                transforms used by the round and key-schedule datapaths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Column c of the block lives in s[3-c], row r of a column in [3-r].
    // This makes the flat 128-bit view put state byte 0 at bits 127:120
    // and word c (most significant first) equal to column c.
    typedef logic [3:0][3:0][7:0] state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        KEYEXP = 3'd2,
        ROUND  = 3'd3,
        OUT    = 3'd4
    } fsm_state_t;

    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] C_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Indexed directly by round number 1..10; unused slots are zero.
    localparam logic [7:0] C_RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {C_SBOX[w[31:24]], C_SBOX[w[23:16]], C_SBOX[w[15:8]], C_SBOX[w[7:0]]};
    endfunction

    // Row r is rotated right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        int     src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = (c - r + 4) % 4;
                o[3-c][3-r] = s[3-src][3-r];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_sub_bytes(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c][r] = C_INV_SBOX[s[c][r]];
            end
        end
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c][3];
            a1 = s[c][2];
            a2 = s[c][1];
            a3 = s[c][0];
            o[c][3] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[c][2] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[c][1] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[c][0] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_key_sched_rev.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_key_sched_rev
//  Description : Round-key register for the inverse cipher. Loads the cipher
//                key word by word, steps forward (k_i -> k_{i+1}) during key
//                expansion and backward (k_{r+1} -> k_r) during the rounds.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                load_en, load_idx     - write key_word into word load_idx
//                key_word              - incoming key word
//                step_en, mode         - advance key; mode 0 fwd, 1 reverse
//                rnd_idx               - Rcon index (1..10) for this step
//                round_key             - next key (result of this step)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_key_sched_rev
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic [1:0]   load_idx,
    input  logic [31:0]  key_word,
    input  logic         step_en,
    input  logic         mode,
    input  logic [3:0]   rnd_idx,
    output logic [127:0] round_key
);

    // Word i of the key is r_key[3-i]; word 0 is the most significant.
    logic [3:0][31:0] r_key;
    logic [31:0]      w_rcon;
    logic [31:0]      w_fwd_t;
    logic [3:0][31:0] w_fwd;
    logic [3:0][31:0] w_rev;

    assign w_rcon = {C_RCON[rnd_idx], 24'h000000};

    always_comb begin
        w_fwd_t  = sub_word(rot_word(r_key[0])) ^ w_rcon;
        w_fwd[3] = r_key[3] ^ w_fwd_t;
        w_fwd[2] = r_key[2] ^ w_fwd[3];
        w_fwd[1] = r_key[1] ^ w_fwd[2];
        w_fwd[0] = r_key[0] ^ w_fwd[1];

        // Reverse step: last three words first, the first word depends on
        // the freshly recovered last word.
        w_rev[0] = r_key[0] ^ r_key[1];
        w_rev[1] = r_key[1] ^ r_key[2];
        w_rev[2] = r_key[2] ^ r_key[3];
        w_rev[3] = r_key[3] ^ sub_word(rot_word(w_rev[0])) ^ w_rcon;
    end

    assign round_key = mode ? w_rev : w_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
        end else if (load_en) begin
            r_key[~load_idx] <= key_word;
        end else if (step_en) begin
            r_key <= round_key;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes128_inv_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_inv_core
//  Description : Iterative AES-128 inverse cipher. Loads 4 ciphertext/key
//                words, expands the key forward over 10 cycles, runs 10
//                inverse rounds (one per cycle) while regenerating round
//                keys backwards, then emits 4 plaintext words.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                ciphertext_in  - ciphertext word (MS word first)
//                key_in         - key word, in lockstep with ciphertext_in
//                MP_dv_in       - input word valid
//                data_out       - plaintext word (registered)
//                core_dv_out    - output word valid (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_inv_core
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ciphertext_in,
    input  logic [DATA_WIDTH-1:0] key_in,
    input  logic                  MP_dv_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  core_dv_out
);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("aes128_inv_core: DATA_WIDTH must be 32");
        end
    endgenerate

    fsm_state_t   r_fsm;
    fsm_state_t   w_fsm_next;
    logic [3:0]   r_cnt;
    state_t       r_state;

    logic         w_load_en;
    logic [1:0]   w_load_idx;
    logic         w_step_en;
    logic         w_mode;
    logic [3:0]   w_rnd_idx;
    logic [127:0] w_round_key;
    state_t       w_ark;
    state_t       w_round_state;

    // ------------------------------------------------------------------
    // Key schedule control
    // ------------------------------------------------------------------
    assign w_load_en  = MP_dv_in && ((r_fsm == IDLE) || (r_fsm == LOAD));
    assign w_load_idx = (r_fsm == IDLE) ? 2'd0 : r_cnt[1:0];
    assign w_step_en  = (r_fsm == KEYEXP) || (r_fsm == ROUND);
    assign w_mode     = (r_fsm == ROUND);

    // KEYEXP step n produces k_{n+1}; ROUND step n recovers k_r with
    // r = 9-n, which needs Rcon_{r+1} = Rcon_{10-n}.
    always_comb begin
        w_rnd_idx = 4'd0;
        if (r_fsm == KEYEXP) w_rnd_idx = r_cnt + 4'd1;
        else if (r_fsm == ROUND) w_rnd_idx = 4'd10 - r_cnt;
    end

    aes128_key_sched_rev u_key_sched (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (w_load_en),
        .load_idx  (w_load_idx),
        .key_word  (key_in),
        .step_en   (w_step_en),
        .mode      (w_mode),
        .rnd_idx   (w_rnd_idx),
        .round_key (w_round_key)
    );

    // ------------------------------------------------------------------
    // Inverse round datapath; the final round (r = 0) skips InvMixColumns
    // ------------------------------------------------------------------
    always_comb begin
        w_ark         = state_t'(inv_sub_bytes(inv_shift_rows(r_state)) ^ w_round_key);
        w_round_state = (r_cnt == 4'd9) ? w_ark : inv_mix_columns(w_ark);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (MP_dv_in) w_fsm_next = LOAD;
            LOAD: begin
                if (!MP_dv_in)            w_fsm_next = IDLE;
                else if (r_cnt == 4'd3)   w_fsm_next = KEYEXP;
            end
            KEYEXP:  if (r_cnt == 4'd9) w_fsm_next = ROUND;
            ROUND:   if (r_cnt == 4'd9) w_fsm_next = OUT;
            // The fifth OUT cycle only drops core_dv_out before idling.
            OUT:     if (r_cnt == 4'd4) w_fsm_next = IDLE;
            default: w_fsm_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_state     <= '0;
            data_out    <= '0;
            core_dv_out <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (MP_dv_in) begin
                        r_state[3] <= ciphertext_in;
                        r_cnt      <= 4'd1;
                    end
                end
                LOAD: begin
                    if (!MP_dv_in) begin
                        r_cnt <= 4'd0;
                    end else begin
                        r_state[~r_cnt[1:0]] <= ciphertext_in;
                        r_cnt <= (r_cnt == 4'd3) ? 4'd0 : r_cnt + 4'd1;
                    end
                end
                KEYEXP: begin
                    if (r_cnt == 4'd9) begin
                        // w_round_key is k10 on this cycle.
                        r_state <= state_t'(r_state ^ w_round_key);
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ROUND: begin
                    r_state <= w_round_state;
                    r_cnt   <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
                end
                OUT: begin
                    if (r_cnt == 4'd4) begin
                        core_dv_out <= 1'b0;
                        r_cnt       <= 4'd0;
                    end else begin
                        data_out    <= r_state[~r_cnt[1:0]];
                        core_dv_out <= 1'b1;
                        r_cnt       <= r_cnt + 4'd1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes128_inv_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_inv_core
//  Description : Self-checking bench for aes128_inv_core. Random blocks are
//                produced by encrypting random plaintext with a behavioural
//                AES-128 forward cipher (S-box derived from GF(2^8) inverse
//                and the affine map), so the DUT must recover the plaintext.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_inv_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ciphertext_in;
    logic [31:0] key_in;
    logic        MP_dv_in;
    logic [31:0] data_out;
    logic        core_dv_out;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] sb [256];

    localparam logic [127:0] V1_CT  = 128'h6f5ddb7f_39560b0f_e9eada49_f87c4904;
    localparam logic [127:0] V1_KEY = 128'h54686174_73204d79_204b756e_67204675;
    localparam logic [127:0] V1_PT  = 128'h41647661_6e636564_20456e63_72797074;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
    localparam logic [127:0] C1_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233_44556677_8899aabb_ccddeeff;

    aes128_inv_core #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ciphertext_in (ciphertext_in),
        .key_in        (key_in),
        .MP_dv_in      (MP_dv_in),
        .data_out      (data_out),
        .core_dv_out   (core_dv_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r+4*c] = s[r+4*((c+r)%4)];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; leaves the bench at the negedge after the edge
    // that samples the last word.
    task automatic send_block(input logic [127:0] ct, input logic [127:0] key);
        for (int w = 0; w < 4; w++) begin
            if (w > 0) @(negedge clk);
            MP_dv_in      = 1'b1;
            ciphertext_in = ct[127-32*w -: 32];
            key_in        = key[127-32*w -: 32];
        end
        @(negedge clk);
        MP_dv_in      = 1'b0;
        ciphertext_in = $urandom;
        key_in        = $urandom;
    endtask

    // Waits for the output burst; lat counts cycles after the last input edge.
    task automatic receive(input int start_lat, output logic [127:0] pt, output int lat,
                           output int first_cyc, output bit ok);
        lat = start_lat; pt = '0; first_cyc = 0; ok = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (core_dv_out) break;
        end
        if (!core_dv_out) return;
        ok = 1'b1;
        first_cyc = cyc;
        pt[127:96] = data_out;
        for (int w = 1; w < 4; w++) begin
            @(negedge clk);
            if (!core_dv_out) ok = 1'b0;
            pt[127-32*w -: 32] = data_out;
        end
        @(negedge clk);
        if (core_dv_out || data_out !== pt[31:0]) ok = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [127:0] ct,
                                 input logic [127:0] key, input logic [127:0] exp_pt);
        logic [127:0] pt; int lat; int fc; bit ok;
        send_block(ct, key);
        receive(0, pt, lat, fc, ok);
        n_total++;
        if (pt !== exp_pt) $display("FAIL %s plaintext: got %h expected %h", name, pt, exp_pt);
        else n_pass++;
        n_total++;
        if (lat !== 21) $display("FAIL %s latency: got %0d expected 21", name, lat);
        else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL %s burst shape: got %0d expected 1", name, ok);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; MP_dv_in = 1'b0; ciphertext_in = '0; key_in = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if (data_out !== 32'h0) $display("FAIL reset data_out: got %h expected 00000000", data_out);
        else n_pass++;
        n_total++;
        if (core_dv_out !== 1'b0) $display("FAIL reset core_dv_out: got %b expected 0", core_dv_out);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        run_and_check("vector1", V1_CT, V1_KEY, V1_PT);
        run_and_check("fips_c1", C1_CT, C1_KEY, C1_PT);
    endtask

    task automatic test_abort();
        int seen = 0;
        MP_dv_in = 1'b1; ciphertext_in = $urandom; key_in = $urandom;
        @(negedge clk); MP_dv_in = 1'b0;
        @(negedge clk);
        MP_dv_in = 1'b1; ciphertext_in = $urandom; key_in = $urandom;
        @(negedge clk); ciphertext_in = $urandom; key_in = $urandom;
        @(negedge clk); MP_dv_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_dv_out) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL abort no_output: got %0d valid cycles expected 0", seen);
        else n_pass++;
        run_and_check("after_abort", C1_CT, C1_KEY, C1_PT);
    endtask

    task automatic test_busy_input();
        logic [127:0] pt, key, ct, got; int lat; int fc; bit ok;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        ct  = aes_encrypt(pt, key);
        send_block(ct, key);
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            if (i < 19) begin
                MP_dv_in = 1'($urandom); ciphertext_in = $urandom; key_in = $urandom;
            end else begin
                MP_dv_in = 1'b0;
            end
        end
        receive(19, got, lat, fc, ok);
        n_total++;
        if (got !== pt) $display("FAIL busy plaintext: got %h expected %h", got, pt);
        else n_pass++;
        n_total++;
        if (lat !== 21) $display("FAIL busy latency: got %0d expected 21", lat);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        send_block(C1_CT, C1_KEY);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (data_out !== 32'h0) $display("FAIL midreset data_out: got %h expected 00000000", data_out);
        else n_pass++;
        n_total++;
        if (core_dv_out !== 1'b0) $display("FAIL midreset core_dv_out: got %b expected 0", core_dv_out);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_and_check("after_midreset", V1_CT, V1_KEY, V1_PT);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa, pb, ka, kb, ga, gb; int la, lb, fa, fb; bit oa, ob;
        pa = {$urandom, $urandom, $urandom, $urandom};
        ka = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        send_block(aes_encrypt(pa, ka), ka);
        receive(0, ga, la, fa, oa);
        send_block(aes_encrypt(pb, kb), kb);
        receive(0, gb, lb, fb, ob);
        n_total++;
        if (ga !== pa) $display("FAIL b2b block_a: got %h expected %h", ga, pa);
        else n_pass++;
        n_total++;
        if (gb !== pb) $display("FAIL b2b block_b: got %h expected %h", gb, pb);
        else n_pass++;
        n_total++;
        if (fb - fa !== 29) $display("FAIL b2b spacing: got %0d expected 29", fb - fa);
        else n_pass++;
        n_total++;
        if (lb !== 21) $display("FAIL b2b latency_b: got %0d expected 21", lb);
        else n_pass++;
        n_total++;
        if ((oa && ob) !== 1'b1) $display("FAIL b2b burst shape: got %0d%0d expected 11", oa, ob);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] pt, key, got; int lat; int fc; bit ok;
        for (int n = 0; n < 8; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            send_block(aes_encrypt(pt, key), key);
            receive(0, got, lat, fc, ok);
            n_total++;
            if (got !== pt || !ok) $display("FAIL random[%0d]: got %h expected %h", n, got, pt);
            else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vectors();
        test_abort();
        test_busy_input();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
